// File: rtl/pc_update_if.sv
// Control/datapath bundle between a multicycle controller and the PC update unit.
// The master drives condition flags, write controls and candidate targets; the slave returns PC state and statistics.
interface pc_update_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             Zero;
    logic             Negative;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [2:0]       BranchCond;
    logic [1:0]       PCSrc;
    logic [WIDTH-1:0] SeqTarget;
    logic [WIDTH-1:0] BranchTarget;
    logic [WIDTH-1:0] JumpTarget;
    logic [WIDTH-1:0] RegTarget;
    logic             Stall;
    logic             Exception;
    logic             Eret;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] EPC;
    logic             Taken;
    logic             AddrError;
    logic [CNT_W-1:0] TakenCount;
    logic [CNT_W-1:0] NotTakenCount;

    modport master (
        output Zero, Negative, PCWrite, PCWriteCond, BranchCond, PCSrc,
               SeqTarget, BranchTarget, JumpTarget, RegTarget,
               Stall, Exception, Eret,
        input  PC, EPC, Taken, AddrError, TakenCount, NotTakenCount
    );

    modport slave (
        input  Zero, Negative, PCWrite, PCWriteCond, BranchCond, PCSrc,
               SeqTarget, BranchTarget, JumpTarget, RegTarget,
               Stall, Exception, Eret,
        output PC, EPC, Taken, AddrError, TakenCount, NotTakenCount
    );
endinterface

// File: rtl/pc_update_unit.sv
// Program counter update unit: conditional/unconditional PC writes, exception entry/return,
// misaligned-target trapping and saturating branch statistics.
module pc_update_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int               CNT_W        = 16
) (
    input logic       clk,
    input logic       rst_n,
    pc_update_if.slave bus
);

    logic [WIDTH-1:0] pcReg, pcNext;
    logic [WIDTH-1:0] epcReg, epcNext;
    logic             takenReg, takenNext;
    logic             addrErrReg, addrErrNext;
    logic [CNT_W-1:0] takenCnt, takenCntNext;
    logic [CNT_W-1:0] notTakenCnt, notTakenCntNext;

    logic             condTrue;
    logic [WIDTH-1:0] target;
    logic             writeEnable;
    logic             misaligned;
    logic             countBranch;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    // NOTE: every combinational output gets a default before the case/if tree, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        condTrue = 1'b0;
        case (bus.BranchCond)
            3'd0:    condTrue = bus.Zero;
            3'd1:    condTrue = !bus.Zero;
            3'd2:    condTrue = bus.Negative | bus.Zero;
            3'd3:    condTrue = !bus.Negative & !bus.Zero;
            3'd4:    condTrue = bus.Negative;
            3'd5:    condTrue = !bus.Negative;
            3'd6:    condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

    always_comb begin
        target = bus.SeqTarget;
        case (bus.PCSrc)
            2'd0:    target = bus.SeqTarget;
            2'd1:    target = bus.BranchTarget;
            2'd2:    target = bus.JumpTarget;
            default: target = bus.RegTarget;
        endcase
    end

    assign writeEnable = bus.PCWrite | (bus.PCWriteCond & condTrue);
    assign misaligned  = writeEnable & (target[1:0] != 2'b00) & !bus.Stall;
    // A rejected (misaligned) branch is still a resolved branch, so it is counted.
    assign countBranch = bus.PCWriteCond & !bus.Stall & !bus.Exception & !bus.Eret;

    always_comb begin
        pcNext          = pcReg;
        epcNext         = epcReg;
        takenNext       = 1'b0;
        addrErrNext     = 1'b0;
        takenCntNext    = takenCnt;
        notTakenCntNext = notTakenCnt;

        if (bus.Exception) begin
            pcNext  = EXC_VECTOR;
            epcNext = pcReg;
        end else if (bus.Eret) begin
            pcNext = epcReg;
        end else if (misaligned) begin
            pcNext      = EXC_VECTOR;
            epcNext     = pcReg;
            addrErrNext = 1'b1;
        end else if (!bus.Stall && writeEnable) begin
            pcNext    = target;
            takenNext = bus.PCWriteCond & !bus.PCWrite & condTrue;
        end

        if (countBranch) begin
            if (condTrue) takenCntNext    = satInc(takenCnt);
            else          notTakenCntNext = satInc(notTakenCnt);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReg       <= RESET_VECTOR;
            epcReg      <= '0;
            takenReg    <= 1'b0;
            addrErrReg  <= 1'b0;
            takenCnt    <= '0;
            notTakenCnt <= '0;
        end else begin
            pcReg       <= pcNext;
            epcReg      <= epcNext;
            takenReg    <= takenNext;
            addrErrReg  <= addrErrNext;
            takenCnt    <= takenCntNext;
            notTakenCnt <= notTakenCntNext;
        end
    end

    assign bus.PC            = pcReg;
    assign bus.EPC           = epcReg;
    assign bus.Taken         = takenReg;
    assign bus.AddrError     = addrErrReg;
    assign bus.TakenCount    = takenCnt;
    assign bus.NotTakenCount = notTakenCnt;

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 Parameter: WIDTH, 32, width of PC, EPC and all target buses.
REQ-002 Parameter: RESET_VECTOR, 0, PC value loaded on reset.
REQ-003 Parameter: EXC_VECTOR, 32'h0000_0180 (truncated to WIDTH), PC value loaded on exception or address error.
REQ-004 Parameter: CNT_W, 16, width of the branch statistics counters.
REQ-005 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port: rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port: Zero, input, 1, ALU zero flag.
REQ-008 Port: Negative, input, 1, ALU sign flag.
REQ-009 Port: PCWrite, input, 1, unconditional PC write.
REQ-010 Port: PCWriteCond, input, 1, conditional PC write, gated by the selected condition.
REQ-011 Port: BranchCond, input, 3, condition select.
REQ-012 Port: PCSrc, input, 2, next-PC source select.
REQ-013 Port: SeqTarget / BranchTarget / JumpTarget / RegTarget, input, WIDTH each, candidate next-PC values.
REQ-014 Port: Stall, input, 1, freezes PC updates.
REQ-015 Port: Exception, input, 1, external exception request.
REQ-016 Port: Eret, input, 1, return from exception.
REQ-017 Port: PC, output, WIDTH, current program counter (registered).
REQ-018 Port: EPC, output, WIDTH, exception PC (registered).
REQ-019 Port: Taken, output, 1, registered one-cycle pulse: conditional branch taken in previous cycle.
REQ-020 Port: AddrError, output, 1, registered one-cycle pulse: misaligned target rejected in previous cycle.
REQ-021 Port: TakenCount / NotTakenCount, output, CNT_W each, branch statistics.

Function
REQ-022 Condition cond_true SHALL be: 0 EQ=Zero; 1 NE=!Zero; 2 LEZ=Negative|Zero; 3 GTZ=!Negative&!Zero; 4 LTZ=Negative; 5 GEZ=!Negative; 6 always=1; 7 never=0.
REQ-023 Target SHALL be selected by PCSrc: 0 SeqTarget, 1 BranchTarget, 2 JumpTarget, 3 RegTarget.
REQ-024 Write enable we SHALL be PCWrite | (PCWriteCond & cond_true).
REQ-025 Misaligned SHALL mean we=1, target[1:0]!=0, Stall=0.
REQ-026 Per edge, priority SHALL be: Exception > Eret > misaligned > Stall > we > hold.
REQ-027 Exception: PC<=EXC_VECTOR, EPC<=PC (current value), regardless of Stall.
REQ-028 Eret (no Exception): PC<=EPC, EPC unchanged, regardless of Stall.
REQ-029 Misaligned: PC<=EXC_VECTOR, EPC<=PC, AddrError<=1 next cycle.
REQ-030 Stall (none of above): PC, EPC, counters unchanged; Taken<=0.
REQ-031 we and no higher event: PC<=target, zero latency to next edge.
REQ-032 Taken SHALL be 1 for exactly one cycle after an edge where PCWriteCond=1, PCWrite=0, cond_true=1, no higher-priority event; else 0.
REQ-033 On each edge with PCWriteCond=1 and no Stall/Exception/Eret, TakenCount (cond_true) or NotTakenCount (!cond_true) SHALL increment by 1; misaligned taken branches count as taken.
REQ-034 Counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-035 AddrError SHALL be 0 in every cycle not following a misaligned event.

Reset
REQ-036 rst_n=0 SHALL immediately, without clock, set PC=RESET_VECTOR, EPC=0, Taken=0, AddrError=0, both counters=0.
REQ-037 Reset asserted mid-operation SHALL discard any pending update; first update occurs on the first rising edge after rst_n=1.

Verification
REQ-038 Reset then PCWriteCond=1, BranchCond=0, Zero=1, PCSrc=1, BranchTarget=0x40 -> PC=0x40 after one edge, Taken=1 for one cycle, TakenCount=1.
REQ-039 BranchCond=1 (NE), Zero=1, PCWriteCond=1 -> PC unchanged, Taken=0, NotTakenCount=1.
REQ-040 PCWrite=1, PCSrc=3, RegTarget=0x102 from PC=0x40 -> PC=0x180, EPC=0x40, AddrError=1 one cycle.
REQ-041 Exception=1 with Stall=1 and PCWrite=1 at PC=0x200 -> PC=0x180, EPC=0x200; next cycle Eret=1 -> PC=0x200.
REQ-042 Preload via CNT_W=2: four taken branches -> TakenCount=3 (saturated), not 0.
REQ-043 rst_n low between edges during a taken branch -> PC=RESET_VECTOR immediately, counters 0, no Taken pulse.
